apb_master_ctrl: RTL and testbench

Parametrised APB3 bridge master between the on-chip request bus (valid/ready) and the peripheral APB segment (GPIO, UART, TIMER, I2C, SPI, PWM).
- Latches each request and decodes a one-hot PSEL from the address.
- Runs the standard SETUP/ACCESS phases with PREADY wait states, PSLVERR capture and a wait-state timeout.
- Returns a one-cycle response pulse carrying read data and an error flag.

---
 rtl/apb_ctrl_pkg.sv | 23 ++
 rtl/apb_addr_decode.sv | 32 +++
 rtl/apb_master_ctrl.sv | 154 +++++++++++++++
 tb/tb_apb_master_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// Shared state encoding, default peripheral slave map and counter sizing
// for the APB master controller and its address decoder.
package apb_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Select-field values of the peripheral segment (address bits [11:8]).
   localparam int GPIO_IDX  = 2;
   localparam int UART_IDX  = 3;
   localparam int TIMER_IDX = 4;
   localparam int I2C_IDX   = 5;
   localparam int SPI_IDX   = 6;
   localparam int PWM_IDX   = 7;

   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave-select decode: address select field -> one-hot PSEL,
// with decode_err for field values outside the mapped window.
module apb_addr_decode #(
   parameter int ADDR_W   = 12,
   parameter int NUM_SLV  = 6,
   parameter int SEL_LSB  = 8,
   parameter int SEL_W    = 4,
   parameter int SLV_BASE = 2
) (
   input  logic [ADDR_W-1:0]  addr,
   output logic [NUM_SLV-1:0] psel,
   output logic               decode_err
);

   localparam logic [SEL_W:0] BASE = (SEL_W + 1)'(SLV_BASE);

   logic [SEL_W:0] idx;
   logic           unused_addr;

   // One extra bit so a field below the base shows up as a set MSB.
   assign idx         = {1'b0, addr[SEL_LSB +: SEL_W]} - BASE;
   assign unused_addr = ^addr;

   always_comb begin
      decode_err = idx[SEL_W] || (int'(idx) >= NUM_SLV);
      psel       = '0;
      if (!decode_err) begin
         psel = NUM_SLV'(1) << idx;
      end
   end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 bridge master: accepts one valid/ready request at a time, runs the
// SETUP/ACCESS handshake and returns a single-cycle response pulse.
module apb_master_ctrl
   import apb_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int NUM_SLV  = 6,
   parameter int SEL_LSB  = 8,
   parameter int SEL_W    = 4,
   parameter int SLV_BASE = GPIO_IDX,
   parameter int TIMEOUT  = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [DATA_W-1:0]  req_wdata,
   output logic               rsp_valid,
   output logic [DATA_W-1:0]  rsp_rdata,
   output logic               rsp_err,
   output logic [NUM_SLV-1:0] psel,
   output logic               penable,
   output logic               pwrite,
   output logic [ADDR_W-1:0]  paddr,
   output logic [DATA_W-1:0]  pwdata,
   input  logic [DATA_W-1:0]  prdata,
   input  logic               pready,
   input  logic               pslverr
);

   localparam int CNT_W = cnt_width(TIMEOUT);

   apb_state_e         state_q, state_d;
   logic [NUM_SLV-1:0] psel_q, psel_d;
   logic               pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]  paddr_q, paddr_d;
   logic [DATA_W-1:0]  pwdata_q, pwdata_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

   logic [NUM_SLV-1:0] dec_psel;
   logic               dec_err;
   logic               timeout_hit;

   apb_addr_decode #(
      .ADDR_W   (ADDR_W),
      .NUM_SLV  (NUM_SLV),
      .SEL_LSB  (SEL_LSB),
      .SEL_W    (SEL_W),
      .SLV_BASE (SLV_BASE)
   ) u_decode (
      .addr       (req_addr),
      .psel       (dec_psel),
      .decode_err (dec_err)
   );

   // The current ACCESS cycle is the TIMEOUT-th one spent waiting.
   assign timeout_hit = (TIMEOUT != 0) && ((int'(cnt_q) + 1) >= TIMEOUT);

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req_valid) begin
               pwrite_d = req_write;
               paddr_d  = req_addr;
               pwdata_d = req_wdata;
               psel_d   = dec_psel;
               if (dec_err) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = pslverr;
               rsp_rdata_d = (pwrite_q || pslverr) ? '0 : prdata;
               psel_d      = '0;
               state_d     = IDLE;
            end else if (timeout_hit) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               psel_d      = '0;
               state_d     = IDLE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            psel_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         psel_q      <= '0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign penable   = (state_q == ACCESS);
   assign psel      = psel_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed vector table, randomized transfers
// against a transaction-level model, and reset / back-to-back sequences.
module tb_apb_master_ctrl;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [11:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [5:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata = '0;
   logic        pready = 1'b0;
   logic        pslverr = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   apb_master_ctrl #(
      .ADDR_W(12), .DATA_W(32), .NUM_SLV(6), .SEL_LSB(8), .SEL_W(4),
      .SLV_BASE(2), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wd;
      int          waits;
      logic [31:0] rd;
      logic        se;
      logic [5:0]  exp_psel;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Transaction-level view: slot from the select field, timeout if the slave
   // waits TO or more cycles, otherwise 3 cycles plus wait states.
   function automatic void ref_model(input logic wr, input logic [11:0] addr, input int waits,
                                     input logic [31:0] rd, input logic se,
                                     output logic [5:0] e_psel, output logic e_err,
                                     output logic [31:0] e_rdata, output int e_lat);
      int slot;
      slot = int'(addr[11:8]) - 2;
      if (slot < 0 || slot >= 6) begin
         e_psel = '0; e_err = 1'b1; e_rdata = '0; e_lat = 1;
      end else if (waits >= TO) begin
         e_psel = 6'(1 << slot); e_err = 1'b1; e_rdata = '0; e_lat = 2 + TO;
      end else begin
         e_psel = 6'(1 << slot); e_err = se; e_rdata = (wr || se) ? 32'd0 : rd; e_lat = 3 + waits;
      end
   endfunction

   task automatic run_txn(input string tag, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wd, input int waits, input logic [31:0] rd,
                          input logic se, input logic [5:0] exp_psel, input logic exp_err,
                          input logic [31:0] exp_rdata, input int exp_lat);
      int          got_lat;
      int          pen_cnt;
      int          bad_psel, bad_pen, bad_rdy, bad_hold;
      logic        in_xfer;
      logic        err_s;
      logic [31:0] rd_s;
      got_lat = -1; pen_cnt = 0; bad_psel = 0; bad_pen = 0; bad_rdy = 0; bad_hold = 0;
      err_s = 1'b0; rd_s = '0;
      @(negedge clk);
      check({tag, "_ready"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_write = 1'($urandom); req_addr = 12'($urandom); req_wdata = $urandom;
      for (int n = 1; n <= 60 && got_lat < 0; n++) begin
         @(negedge clk);
         in_xfer = (exp_lat > 1) && (n < exp_lat);
         if (psel !== (in_xfer ? exp_psel : 6'd0)) bad_psel++;
         if (penable !== (in_xfer && n >= 2)) bad_pen++;
         if (req_ready !== !in_xfer) bad_rdy++;
         if (in_xfer && (paddr !== addr || pwrite !== wr || pwdata !== wd)) bad_hold++;
         if (rsp_valid === 1'b1) begin
            got_lat = n; err_s = rsp_err; rd_s = rsp_rdata;
         end
         if (penable === 1'b1) pen_cnt++;
         pready  = (penable === 1'b1) && (pen_cnt > waits);
         pslverr = pready ? se : 1'($urandom);
         prdata  = pready ? rd : $urandom;
      end
      pready = 1'b0;
      check({tag, "_lat"}, 64'(got_lat), 64'(exp_lat));
      check({tag, "_psel_seq"}, 64'(bad_psel), 64'd0);
      check({tag, "_penable_seq"}, 64'(bad_pen), 64'd0);
      check({tag, "_ready_seq"}, 64'(bad_rdy), 64'd0);
      check({tag, "_hold"}, 64'(bad_hold), 64'd0);
      check({tag, "_err"}, 64'(err_s), 64'(exp_err));
      check({tag, "_rdata"}, 64'(rd_s), 64'(exp_rdata));
      @(negedge clk);
      check({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
      check({tag, "_held"}, 64'({rsp_err, rsp_rdata}), 64'({exp_err, exp_rdata}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      logic [5:0]  m_psel;
      logic        m_err;
      logic [31:0] m_rdata;
      int          m_lat;
      logic        r_wr, r_se;
      logic [11:0] r_addr;
      logic [31:0] r_wd, r_rd;
      int          r_waits;
      int          rv;

      //            wr    addr     wdata          waits rdata          se    psel        err   rdata          lat
      vecs[0]  = '{1'b1, 12'h204, 32'hDEADBEEF,  0, 32'h0,         1'b0, 6'b000001, 1'b0, 32'h0,         3};
      vecs[1]  = '{1'b0, 12'h510, 32'h0,         4, 32'h12345678,  1'b0, 6'b001000, 1'b0, 32'h12345678,  7};
      vecs[2]  = '{1'b0, 12'h100, 32'h0,         0, 32'h0,         1'b0, 6'b000000, 1'b1, 32'h0,         1};
      vecs[3]  = '{1'b1, 12'h800, 32'h55AA55AA,  0, 32'h0,         1'b0, 6'b000000, 1'b1, 32'h0,         1};
      vecs[4]  = '{1'b1, 12'h700, 32'h0BADF00D,  0, 32'h0,         1'b1, 6'b100000, 1'b1, 32'h0,         3};
      vecs[5]  = '{1'b0, 12'h3FC, 32'h0,        20, 32'hFFFFFFFF,  1'b0, 6'b000010, 1'b1, 32'h0,        10};
      vecs[6]  = '{1'b0, 12'h6A0, 32'h0,         7, 32'hCAFEF00D,  1'b0, 6'b010000, 1'b0, 32'hCAFEF00D, 10};
      vecs[7]  = '{1'b0, 12'h4FF, 32'h0,         2, 32'hA5A5A5A5,  1'b1, 6'b000100, 1'b1, 32'h0,         5};
      vecs[8]  = '{1'b0, 12'hF00, 32'h0,         0, 32'h0,         1'b0, 6'b000000, 1'b1, 32'h0,         1};
      vecs[9]  = '{1'b0, 12'h000, 32'h0,         0, 32'h0,         1'b0, 6'b000000, 1'b1, 32'h0,         1};
      vecs[10] = '{1'b0, 12'h200, 32'h0,         0, 32'h00000001,  1'b0, 6'b000001, 1'b0, 32'h00000001,  3};
      vecs[11] = '{1'b0, 12'h7FF, 32'h0,         1, 32'h80000000,  1'b0, 6'b100000, 1'b0, 32'h80000000,  4};

      #2 rst = 1'b0;
      #1;
      check("rst_psel", 64'(psel), 64'd0);
      check("rst_penable", 64'(penable), 64'd0);
      check("rst_pwrite", 64'(pwrite), 64'd0);
      check("rst_paddr", 64'(paddr), 64'd0);
      check("rst_pwdata", 64'(pwdata), 64'd0);
      check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'd1);

      for (int i = 0; i < 12; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].waits,
                 vecs[i].rd, vecs[i].se, vecs[i].exp_psel, vecs[i].exp_err,
                 vecs[i].exp_rdata, vecs[i].exp_lat);
      end

      for (int i = 0; i < 40; i++) begin
         r_wr    = 1'($urandom);
         r_addr  = {4'($urandom_range(0, 15)), 8'($urandom)};
         r_wd    = $urandom;
         r_rd    = $urandom;
         r_se    = ($urandom_range(0, 3) == 0);
         r_waits = int'($urandom_range(0, 10));
         ref_model(r_wr, r_addr, r_waits, r_rd, r_se, m_psel, m_err, m_rdata, m_lat);
         run_txn($sformatf("rnd%0d", i), r_wr, r_addr, r_wd, r_waits, r_rd, r_se,
                 m_psel, m_err, m_rdata, m_lat);
      end

      // Reset while the slave is stalling in ACCESS.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h300;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_pre_penable", 64'(penable), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_psel", 64'(psel), 64'd0);
      check("mid_rst_penable", 64'(penable), 64'd0);
      check("mid_rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      rv = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) rv++;
      end
      check("mid_no_rsp", 64'(rv), 64'd0);
      check("mid_ready", 64'(req_ready), 64'd1);

      // Back-to-back reads: the second accept lands on the first response.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h300; req_wdata = '0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("b2b_setup_psel", 64'(psel), 64'(6'b000010));
      check("b2b_setup_pen", 64'(penable), 64'd0);
      @(negedge clk);
      check("b2b_access_pen", 64'(penable), 64'd1);
      pready = 1'b1; prdata = 32'h11112222; pslverr = 1'b0;
      @(negedge clk);
      pready = 1'b0; prdata = '0;
      check("b2b_rsp1_valid", 64'(rsp_valid), 64'd1);
      check("b2b_rsp1_rdata", 64'(rsp_rdata), 64'h11112222);
      check("b2b_ready_on_rsp", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_addr = 12'h400;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("b2b_psel2", 64'(psel), 64'(6'b000100));
      check("b2b_rsp1_pulse", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check("b2b_access2_pen", 64'(penable), 64'd1);
      pready = 1'b1; prdata = 32'h33334444;
      @(negedge clk);
      pready = 1'b0; prdata = '0;
      check("b2b_rsp2_valid", 64'(rsp_valid), 64'd1);
      check("b2b_rsp2", 64'({rsp_err, rsp_rdata}), 64'({1'b0, 32'h33334444}));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
